// File: rtl/fb_pkg.sv
// fb_pkg: screen geometry, word layout and lane helpers
// shared by the framebuffer writer and its FIFO.
package fb_pkg;

  localparam int SCREEN_W        = 320;
  localparam int SCREEN_H        = 180;
  localparam int PIXELS_PER_WORD = 8;
  localparam int WORDS_PER_ROW   = 40;
  localparam int WORDS_PER_FRAME = 7200;
  localparam int FB_ADDR_W       = 27;

  typedef struct packed {
    logic                 last;
    logic [FB_ADDR_W-1:0] addr;
    logic [15:0]          strb;
    logic [127:0]         data;
  } fb_word_t;

  function automatic logic [15:0] lane_strb(input logic [2:0] lane);
    return 16'b11 << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: synchronous first-word-fall-through FIFO.
// A push when full is ignored unless a pop happens on the same edge.
module fb_word_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  // pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: packs RGB565 pixels into 128-bit DRAM words
// and double-buffers frames. Optional macro: FB_WRITER_STATS_EN.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int          ADDR_W     = 27,
  parameter int unsigned FB0_BASE   = 0,
  parameter int unsigned FB1_BASE   = 8192,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        pix_h,
  input  logic [7:0]        pix_v,
  input  logic              pix_valid,
  input  logic              pix_last,
  input  logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      wr_data,
  output logic [15:0]       wr_strb,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              frame_written,
  output logic              display_frame,
  output logic              overflow
`ifdef FB_WRITER_STATS_EN
  ,
  output logic [15:0]       words_last_frame
`endif
);

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       strb;
    logic [127:0]      data;
  } word_t;

  logic              write_buf;
  logic              acc_valid;
  logic              acc_full;
  logic              acc_last;
  logic [ADDR_W-1:0] acc_addr;
  logic [127:0]      acc_data;
  logic [15:0]       acc_strb;

  logic              in_range;
  logic              accept;
  logic              drop_last;
  logic              push;
  logic              push_last;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        lane;
  logic [15:0]       mask;

  logic              ghost_pend;
  logic              ghost_buf;
  logic              ghost_fire;
  logic              head_acc;
  logic              head_last;
  logic              fw_set;

  word_t             push_word;
  word_t             head;
  logic              fifo_full;
  logic              fifo_empty;

  assign in_range  = (pix_h < 9'(SCREEN_W)) &&
                     (pix_v < 8'(SCREEN_H));
  assign accept    = pix_valid && in_range;
  assign drop_last = pix_valid && pix_last && !in_range;
  assign base      = write_buf ? ADDR_W'(FB1_BASE)
                               : ADDR_W'(FB0_BASE);
  assign addr      = base
                   + ADDR_W'(pix_v) * ADDR_W'(WORDS_PER_ROW)
                   + ADDR_W'(pix_h[8:3]);
  assign lane      = pix_h[2:0];
  assign mask      = lane_strb(lane);

  assign push      = acc_valid &&
                     (acc_full || acc_last ||
                      (pix_valid && (addr != acc_addr)));
  assign push_last = acc_last || drop_last;

  assign push_word = '{last: push_last, addr: acc_addr,
                       strb: acc_strb, data: acc_data};

  assign wr_valid  = !fifo_empty;
  assign wr_addr   = head.addr;
  assign wr_data   = head.data;
  assign wr_strb   = head.strb;

  assign head_acc  = wr_valid && wr_ready;
  assign head_last = head_acc && head.last;
  assign ghost_fire = ghost_pend && fifo_empty;
  assign fw_set    = head_last || ghost_fire;

  fb_word_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (wr_ready),
    .din   (push_word),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pixel accumulator: start, merge or retire the pending word
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc_full  <= 1'b0;
      acc_last  <= 1'b0;
      acc_addr  <= '0;
      acc_data  <= '0;
      acc_strb  <= '0;
    end else if (accept) begin
      if (push || !acc_valid) begin
        acc_valid <= 1'b1;
        acc_addr  <= addr;
        acc_data  <= 128'(pix_data) << {lane, 4'b0000};
        acc_strb  <= mask;
        acc_full  <= 1'b0;
        acc_last  <= pix_last;
      end else begin
        acc_data[{lane, 4'b0000} +: 16] <= pix_data;
        acc_strb <= acc_strb | mask;
        acc_full <= ((acc_strb | mask) == 16'hFFFF);
        acc_last <= pix_last;
      end
    end else if (push) begin
      acc_valid <= 1'b0;
      acc_full  <= 1'b0;
      acc_last  <= 1'b0;
      acc_strb  <= '0;
    end else if (drop_last && acc_valid) begin
      acc_last <= 1'b1;
    end
  end

  // buffer swap, frame completion and overflow tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      write_buf     <= 1'b0;
      ghost_pend    <= 1'b0;
      ghost_buf     <= 1'b0;
      frame_written <= 1'b0;
      display_frame <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      if ((push && push_last) || (drop_last && !acc_valid))
        write_buf <= ~write_buf;
      if (drop_last && !acc_valid) begin
        ghost_pend <= 1'b1;
        ghost_buf  <= write_buf;
      end else if (ghost_fire) begin
        ghost_pend <= 1'b0;
      end
      frame_written <= fw_set;
      if (head_last)
        display_frame <= (head.addr >= ADDR_W'(FB1_BASE));
      else if (ghost_fire)
        display_frame <= ghost_buf;
      if (push && fifo_full && !wr_ready)
        overflow <= 1'b1;
    end
  end

`ifdef FB_WRITER_STATS_EN
  logic [15:0] word_cnt;

  // count accepted words and latch the total at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt         <= '0;
      words_last_frame <= '0;
    end else if (fw_set) begin
      words_last_frame <= word_cnt + 16'(head_acc);
      word_cnt         <= '0;
    end else if (head_acc) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: directed + randomized bench with a
// pixel-array reference model and a write scoreboard.
module tb_framebuffer_writer;

  typedef struct packed {
    logic [26:0]  a;
    logic [15:0]  s;
    logic [127:0] d;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [8:0]   pix_h = '0;
  logic [7:0]   pix_v = '0;
  logic         pix_valid = 1'b0;
  logic         pix_last = 1'b0;
  logic [15:0]  pix_data = '0;
  logic [26:0]  wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic         wr_valid;
  logic         wr_ready = 1'b1;
  logic         frame_written;
  logic         display_frame;
  logic         overflow;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int fw_cnt = 0;
  int fw_cyc = -1;
  int acc_cyc = -1;
  bit rand_ready = 1'b0;
  logic [15:0] pixmem [57600];
  wr_t act [$];

  framebuffer_writer dut (
    .clk           (clk),
    .rst           (rst),
    .pix_h         (pix_h),
    .pix_v         (pix_v),
    .pix_valid     (pix_valid),
    .pix_last      (pix_last),
    .pix_data      (pix_data),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .frame_written (frame_written),
    .display_frame (display_frame),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard capture, away from the active edge
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      act.push_back('{wr_addr, wr_strb, wr_data});
      acc_cyc = cyc;
    end
    if (!rst && frame_written) begin
      fw_cnt++;
      fw_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pix(input int h, input int v,
                     input logic [15:0] d, input logic last);
    pix_h     = 9'(h);
    pix_v     = 8'(v);
    pix_data  = d;
    pix_last  = last;
    pix_valid = 1'b1;
    if (h < 320 && v < 180) pixmem[v*320+h] = d;
    if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    step();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_acts(input int n, input int budget,
                           input string tag);
    int t = 0;
    while (act.size() < n && t < budget) begin
      step();
      t++;
    end
    chk(tag, 128'(act.size()), 128'(n));
  endtask

  function automatic logic [127:0] exp_data(input int v, input int w);
    logic [127:0] d = '0;
    for (int k = 0; k < 8; k++)
      d[16*k +: 16] = pixmem[v*320 + w*8 + k];
    return d;
  endfunction

  task automatic chk_words(input string tag, input int a0,
                           input int v0, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= act.size()) bad++;
      else if (act[i].a !== 27'(a0 + i) ||
               act[i].s !== 16'hFFFF ||
               act[i].d !== exp_data(v0 + i/40, i%40)) bad++;
    end
    chk(tag, 128'(bad), 128'(0));
  endtask

  initial begin
    logic [15:0]  a, b, c;
    logic [127:0] m, e;
    int fw0;

    idle(3);
    rst = 1'b0;
    chk("rst wr_valid", 128'(wr_valid), 128'(0));
    chk("rst frame_written", 128'(frame_written), 128'(0));
    chk("rst overflow", 128'(overflow), 128'(0));
    chk("rst display_frame", 128'(display_frame), 128'(1));

    // one full word, latency and content
    for (int h = 0; h < 8; h++)
      pix(h, 0, 16'(16'h1111 * (h + 1)), 1'b0);
    chk("t1 valid early", 128'(wr_valid), 128'(0));
    step();
    chk("t1 valid", 128'(wr_valid), 128'(1));
    chk("t1 addr", 128'(wr_addr), 128'(0));
    chk("t1 strb", 128'(wr_strb), 128'(16'hFFFF));
    chk("t1 data", wr_data,
        128'h8888_7777_6666_5555_4444_3333_2222_1111);
    idle(5);
    chk("t1 count", 128'(act.size()), 128'(1));
    act.delete();

    // partial word flushed by an address change, then by a dropped pixel
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    pix(3, 0, a, 1'b0);
    pix(4, 0, b, 1'b0);
    pix(16, 0, c, 1'b0);
    wait_acts(1, 20, "t3 first count");
    m = 128'hFFFF_FFFF << 48;
    e = (128'(b) << 64) | (128'(a) << 48);
    if (act.size() > 0) begin
      chk("t3 addr0", 128'(act[0].a), 128'(0));
      chk("t3 strb0", 128'(act[0].s), 128'(16'h03C0));
      chk("t3 data0", act[0].d & m, e);
    end
    idle(10);
    chk("t3 held", 128'(act.size()), 128'(1));
    pix(400, 0, 16'($urandom), 1'b0);
    wait_acts(2, 20, "t3 second count");
    if (act.size() > 1) begin
      chk("t3 addr1", 128'(act[1].a), 128'(2));
      chk("t3 strb1", 128'(act[1].s), 128'(16'h0003));
      chk("t3 data1", 128'(act[1].d[15:0]), 128'(c));
    end
    idle(10);
    chk("t3 no extra", 128'(act.size()), 128'(2));
    act.delete();

    // full row with random backpressure
    rand_ready = 1'b1;
    for (int h = 0; h < 320; h++)
      pix(h, 2, 16'($urandom), 1'b0);
    rand_ready = 1'b0;
    wr_ready = 1'b1;
    wait_acts(40, 200, "row count");
    chk_words("row words", 80, 2, 40);
    idle(5);
    act.delete();

    // complete frame, buffer swap on last pixel
    fw_cnt = 0;
    for (int v = 0; v < 180; v++)
      for (int h = 0; h < 320; h++)
        pix(h, v, 16'($urandom), 1'(h == 319 && v == 179));
    wait_acts(7200, 200, "frame count");
    idle(5);
    chk_words("frame words", 0, 0, 7200);
    chk("frame fw pulses", 128'(fw_cnt), 128'(1));
    chk("frame fw timing", 128'(fw_cyc), 128'(acc_cyc + 1));
    chk("frame display", 128'(display_frame), 128'(0));
    act.delete();
    for (int h = 0; h < 8; h++)
      pix(h, 0, 16'($urandom), 1'b0);
    wait_acts(1, 20, "next frame count");
    if (act.size() > 0)
      chk("next frame addr", 128'(act[0].a), 128'(8192));
    idle(5);
    act.delete();

    // overflow: 17 words with the port stalled
    wr_ready = 1'b0;
    for (int h = 0; h < 136; h++)
      pix(h, 5, 16'($urandom), 1'b0);
    idle(4);
    chk("ovf set", 128'(overflow), 128'(1));
    wr_ready = 1'b1;
    wait_acts(16, 100, "ovf drained");
    idle(10);
    chk("ovf exact 16", 128'(act.size()), 128'(16));
    chk_words("ovf words", 8192 + 200, 5, 16);
    chk("ovf sticky", 128'(overflow), 128'(1));
    act.delete();

    // reset mid-row with the FIFO holding data
    wr_ready = 1'b0;
    for (int h = 0; h < 12; h++)
      pix(h, 0, 16'($urandom), 1'b0);
    idle(2);
    chk("pre-rst valid", 128'(wr_valid), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-rst valid", 128'(wr_valid), 128'(0));
    chk("mid-rst overflow", 128'(overflow), 128'(0));
    chk("mid-rst display", 128'(display_frame), 128'(1));
    wr_ready = 1'b1;
    for (int h = 0; h < 8; h++)
      pix(h, 0, 16'($urandom), 1'b0);
    wait_acts(1, 20, "post-rst count");
    idle(10);
    chk("post-rst single", 128'(act.size()), 128'(1));
    if (act.size() > 0) begin
      chk("post-rst addr", 128'(act[0].a), 128'(0));
      chk("post-rst data", act[0].d, exp_data(0, 0));
    end

    // dropped last pixel with an empty accumulator
    fw0 = fw_cnt;
    pix(320, 0, 16'($urandom), 1'b1);
    idle(5);
    chk("ghost fw", 128'(fw_cnt), 128'(fw0 + 1));
    chk("ghost display", 128'(display_frame), 128'(0));
    chk("ghost no write", 128'(act.size()), 128'(1));
    act.delete();
    for (int h = 0; h < 8; h++)
      pix(h, 0, 16'($urandom), 1'b0);
    wait_acts(1, 20, "ghost next count");
    if (act.size() > 0)
      chk("ghost next addr", 128'(act[0].a), 128'(8192));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
